wbu: RTL and testbench
======================

Name: wbu

Overview:
- Write-back / commit stage, directly downstream of the load-store unit.
- Captures one retiring instruction from the LSU-to-WBU bus (`LSU_WBU_BUS_WIDTH`) on the LSU valid pulse.
- Commits it: GPR write, CSR write, and trap/xret signalling to the CSR file.
- Owns the architectural PC, computes the next PC, and hands it to the IFU with a one-cycle valid pulse; counts retired instructions and halts on ebreak.

Parameters:
- RESET_PC, 32'h8000_0000, architectural PC after reset.
- BUS_W, 119, width of the LSU-to-WBU bus; must equal `LSU_WBU_BUS_WIDTH`.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- lsu_valid_i  in  1  one-cycle pulse; lsu_wbu_bus_i is valid this cycle.
- lsu_wbu_bus_i  in  119  MSB..LSB: csr_we(1), result(32), gr_we(1), rd(5), csr_addr(12), csr_wdata(32), jmp_flag(1), jmp_target(32), break(1), excp_flush(1), xret_flush(1).
- mtvec_i  in  32  trap vector from the CSR file.
- mepc_i  in  32  return PC from the CSR file.
- rf_we_o  out  1  GPR write enable.
- rf_waddr_o  out  5  GPR index.
- rf_wdata_o  out  32  GPR data.
- csr_we_o  out  1  CSR write enable.
- csr_waddr_o  out  12  CSR address.
- csr_wdata_o  out  32  CSR data.
- excp_o  out  1  trap-entry pulse; CSR file latches mepc<=epc_o.
- epc_o  out  32  PC of the trapping instruction.
- pc_o  out  32  architectural PC; new value is visible when wbu_valid_o is high.
- wbu_valid_o  out  1  one-cycle pulse to the IFU: fetch at pc_o.
- halt_o  out  1  sticky; set on ebreak.
- retired_o  out  64  retired-instruction count.
- proto_err_o  out  1  sticky; lsu_valid_i arrived while the block was busy.

Behaviour:
- Reset (async):
  - state=IDLE, pc=RESET_PC, retired=0, latched bus=0.
  - All outputs 0 except pc_o=RESET_PC.
  - Reset mid-COMMIT or mid-DONE aborts: no write pulse and no valid pulse.
- FSM states: IDLE, COMMIT, DONE, HALT.
- IDLE:
  - On lsu_valid_i: latch the bus and go to COMMIT.
  - Otherwise remain.
- COMMIT (exactly 1 cycle); outputs are driven from the latched bus:
  - rf_we_o = gr_we && rd!=0 && !excp_flush. Writes to x0 are always suppressed.
  - rf_waddr_o=rd, rf_wdata_o=result.
  - csr_we_o = csr_we && !excp_flush; csr_waddr_o/csr_wdata_o from the bus.
  - excp_o = excp_flush; epc_o = pc.
  - Next-PC priority, registered at end of cycle:
    1. excp_flush -> mtvec_i
    2. xret_flush -> mepc_i
    3. jmp_flag -> jmp_target
    4. otherwise pc+4 (mod 2^32)
  - retired += 1 unless excp_flush. Counter wraps at 2^64.
  - If break: go to HALT; halt_o<=1; pc is not updated; retired += 1.
  - Else go to DONE.
- DONE (1 cycle): wbu_valid_o=1 with pc_o holding the new PC; then go to IDLE.
- HALT: absorbing until reset. wbu_valid_o stays 0 and lsu_valid_i is ignored without setting proto_err_o.
- Outside COMMIT: rf_we_o, csr_we_o and excp_o are 0.
- Latency: lsu_valid_i at cycle N -> write enables at N+1 -> wbu_valid_o at N+2. Minimum commit interval is 3 cycles.
- Protocol violation:
  - lsu_valid_i in COMMIT or DONE is dropped (the latched bus is unchanged).
  - proto_err_o <= 1 (sticky).
- Simultaneous excp_flush and xret_flush: trap wins.
- Simultaneous excp_flush and jmp_flag: trap wins.

Decomposition:
- Shared header riscv_param.vh holds:
  - the FSM state encodings;
  - `LSU_WBU_BUS_WIDTH`;
  - bus field offset macros, so lsu and wbu pack and unpack from one definition;
  - the RESET_PC default.
- Sub-module wbu_npc: combinational next-PC priority mux.
- All state stays in wbu.

Test Plan:
1. Reset released, bus{gr_we=1, rd=5, result=32'h1234} pulsed -> cycle+1: rf_we_o=1, waddr=5, wdata=32'h1234; cycle+2: wbu_valid_o=1, pc_o=32'h8000_0004; retired_o=1.
2. gr_we=1, rd=0 -> rf_we_o stays 0; pc_o=32'h8000_0004; retired_o increments.
3. jmp_flag=1, jmp_target=32'h8000_0100, gr_we=1, rd=1, result=32'h8000_0004 -> x1 written; pc_o=32'h8000_0100.
4. excp_flush=1 with gr_we=1, mtvec_i=32'h8000_0800, pc=32'h8000_0010 -> rf_we_o=0, excp_o pulse, epc_o=32'h8000_0010, pc_o=32'h8000_0800, retired_o unchanged. Then xret_flush=1 with mepc_i=32'h8000_0010 -> pc_o=32'h8000_0010.
5. break=1 -> halt_o=1, no wbu_valid_o. A further lsu_valid_i has no effect and proto_err_o stays 0. Assert reset -> halt_o=0, pc_o=32'h8000_0000.
6. lsu_valid_i pulsed on two consecutive cycles -> only the first is committed; proto_err_o=1; retired_o +1.

Source files
------------

// File: rtl/wbu_pkg.sv
// wbu_pkg: LSU->WBU bus layout (macros + packed struct), FSM states and reset PC shared by lsu/wbu
`ifndef RISCV_PARAM_VH
`define RISCV_PARAM_VH
`define LSU_WBU_BUS_WIDTH 119
`define BUS_XRET_FLUSH 0
`define BUS_EXCP_FLUSH 1
`define BUS_BREAK 2
`define BUS_JMP_TARGET 3
`define BUS_JMP_FLAG 35
`define BUS_CSR_WDATA 36
`define BUS_CSR_ADDR 68
`define BUS_RD 80
`define BUS_GR_WE 85
`define BUS_RESULT 86
`define BUS_CSR_WE 118
`endif

package wbu_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  typedef enum logic [1:0] {IDLE = 2'd0, COMMIT = 2'd1, DONE = 2'd2, HALT = 2'd3} wbu_state_t;
  typedef struct packed {
    logic        csr_we;
    logic [31:0] result;
    logic        gr_we;
    logic [4:0]  rd;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        jmp_flag;
    logic [31:0] jmp_target;
    logic        brk;
    logic        excp_flush;
    logic        xret_flush;
  } lsu_wbu_bus_t;
endpackage

// File: rtl/wbu_npc.sv
// wbu_npc: next-PC priority mux (trap > xret > jump > sequential)
module wbu_npc (
  input  logic [31:0] pc,
  input  logic        excp,
  input  logic        xret,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [31:0] npc
);
  always_comb begin
    npc = excp ? mtvec : xret ? mepc : jmp ? jmp_target : pc + 32'd4;
  end
endmodule

// File: rtl/wbu.sv
// wbu: write-back/commit stage; commits one LSU result, owns the architectural PC and retire count
module wbu
  import wbu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          BUS_W    = `LSU_WBU_BUS_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             lsu_valid_i,
  input  logic [BUS_W-1:0] lsu_wbu_bus_i,
  input  logic [31:0]      mtvec_i,
  input  logic [31:0]      mepc_i,
  output logic             rf_we_o,
  output logic [4:0]       rf_waddr_o,
  output logic [31:0]      rf_wdata_o,
  output logic             csr_we_o,
  output logic [11:0]      csr_waddr_o,
  output logic [31:0]      csr_wdata_o,
  output logic             excp_o,
  output logic [31:0]      epc_o,
  output logic [31:0]      pc_o,
  output logic             wbu_valid_o,
  output logic             halt_o,
  output logic [63:0]      retired_o,
  output logic             proto_err_o
);
  wbu_state_t   state, state_n;
  lsu_wbu_bus_t bus_q;
  logic [31:0]  pc, npc;
  logic [63:0]  retired;
  logic         halt, proto_err, commit, busy;

  assign commit = state == COMMIT;
  assign busy   = state == COMMIT || state == DONE;

  wbu_npc u_npc (
    .pc(pc),
    .excp(bus_q.excp_flush),
    .xret(bus_q.xret_flush),
    .jmp(bus_q.jmp_flag),
    .jmp_target(bus_q.jmp_target),
    .mtvec(mtvec_i),
    .mepc(mepc_i),
    .npc(npc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state == IDLE   ? (lsu_valid_i ? COMMIT : IDLE) :
              state == COMMIT ? (bus_q.brk ? HALT : DONE) :
              state == DONE   ? IDLE : HALT;
  end

  // pulses arriving while busy are dropped; the latched bus only loads in IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      retired   <= '0;
      bus_q     <= '0;
      halt      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (state == IDLE && lsu_valid_i) bus_q <= lsu_wbu_bus_t'(lsu_wbu_bus_i);
      if (busy && lsu_valid_i) proto_err <= 1'b1;
      if (commit) begin
        retired <= retired + {63'd0, !bus_q.excp_flush};
        if (bus_q.brk) halt <= 1'b1;
        else pc <= npc;
      end
    end
  end

  assign rf_we_o     = commit && bus_q.gr_we && |bus_q.rd && !bus_q.excp_flush;
  assign rf_waddr_o  = bus_q.rd;
  assign rf_wdata_o  = bus_q.result;
  assign csr_we_o    = commit && bus_q.csr_we && !bus_q.excp_flush;
  assign csr_waddr_o = bus_q.csr_addr;
  assign csr_wdata_o = bus_q.csr_wdata;
  assign excp_o      = commit && bus_q.excp_flush;
  assign epc_o       = commit ? pc : '0;
  assign pc_o        = pc;
  assign wbu_valid_o = state == DONE;
  assign halt_o      = halt;
  assign retired_o   = retired;
  assign proto_err_o = proto_err;
endmodule

// File: tb/tb_wbu.sv
// tb_wbu: directed scoreboard bench for the write-back stage
module tb_wbu;
  import wbu_pkg::*;

  logic clock = 1'b0, reset = 1'b0, lsu_valid_i = 1'b0;
  logic [`LSU_WBU_BUS_WIDTH-1:0] lsu_wbu_bus_i = '0;
  logic [31:0] mtvec_i = 32'h8000_0800, mepc_i = 32'h8000_0010;
  logic rf_we_o, csr_we_o, excp_o, wbu_valid_o, halt_o, proto_err_o;
  logic [4:0] rf_waddr_o;
  logic [31:0] rf_wdata_o, csr_wdata_o, epc_o, pc_o;
  logic [11:0] csr_waddr_o;
  logic [63:0] retired_o;

  typedef struct {
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        csr_we;
    logic [11:0] caddr;
    logic [31:0] cdata;
    logic        excp;
    logic [31:0] epc;
    logic [31:0] npc;
    logic [63:0] ret;
    logic        brk;
  } exp_t;

  exp_t q[$];
  int vectors = 0, miscompares = 0;
  logic [31:0] m_pc;
  logic [63:0] m_ret;
  lsu_wbu_bus_t b;
  logic seen;

  always #5 clock = ~clock;

  wbu dut (
    .clock(clock), .reset(reset), .lsu_valid_i(lsu_valid_i), .lsu_wbu_bus_i(lsu_wbu_bus_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
    .csr_wdata_o(csr_wdata_o), .excp_o(excp_o), .epc_o(epc_o), .pc_o(pc_o),
    .wbu_valid_o(wbu_valid_o), .halt_o(halt_o), .retired_o(retired_o), .proto_err_o(proto_err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input lsu_wbu_bus_t bb);
    exp_t e;
    logic got;
    e.rf_we  = bb.gr_we && bb.rd != 5'd0 && !bb.excp_flush;
    e.waddr  = bb.rd;
    e.wdata  = bb.result;
    e.csr_we = bb.csr_we && !bb.excp_flush;
    e.caddr  = bb.csr_addr;
    e.cdata  = bb.csr_wdata;
    e.excp   = bb.excp_flush;
    e.epc    = m_pc;
    if (bb.excp_flush) e.npc = mtvec_i;
    else if (bb.xret_flush) e.npc = mepc_i;
    else if (bb.jmp_flag) e.npc = bb.jmp_target;
    else e.npc = m_pc + 32'd4;
    if (bb.brk) e.npc = m_pc;
    e.ret = m_ret + (bb.excp_flush ? 64'd0 : 64'd1);
    e.brk = bb.brk;
    q.push_back(e);
    m_pc  = e.npc;
    m_ret = e.ret;
    @(negedge clock);
    lsu_valid_i   = 1'b1;
    lsu_wbu_bus_i = bb;
    @(negedge clock);
    lsu_valid_i = 1'b0;
    check("rf_we", 64'(rf_we_o), 64'(q[0].rf_we));
    if (q[0].rf_we) begin
      check("rf_waddr", 64'(rf_waddr_o), 64'(q[0].waddr));
      check("rf_wdata", 64'(rf_wdata_o), 64'(q[0].wdata));
    end
    check("csr_we", 64'(csr_we_o), 64'(q[0].csr_we));
    if (q[0].csr_we) begin
      check("csr_waddr", 64'(csr_waddr_o), 64'(q[0].caddr));
      check("csr_wdata", 64'(csr_wdata_o), 64'(q[0].cdata));
    end
    check("excp", 64'(excp_o), 64'(q[0].excp));
    check("epc", 64'(epc_o), 64'(q[0].epc));
    check("valid_in_commit", 64'(wbu_valid_o), 64'd0);
    if (q[0].brk) begin
      @(negedge clock);
      e = q.pop_front();
      check("halt", 64'(halt_o), 64'd1);
      check("valid_on_halt", 64'(wbu_valid_o), 64'd0);
      check("pc_halt", 64'(pc_o), 64'(e.npc));
      check("retired_halt", retired_o, e.ret);
    end else begin
      got = 1'b0;
      for (int i = 0; i < 4 && !got; i++) begin
        @(negedge clock);
        got = wbu_valid_o;
      end
      check("valid_seen", 64'(got), 64'd1);
      e = q.pop_front();
      check("pc", 64'(pc_o), 64'(e.npc));
      check("retired", retired_o, e.ret);
      check("write_gone", 64'({rf_we_o, csr_we_o, excp_o}), 64'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_pc", 64'(pc_o), 64'h8000_0000);
    check("rst_retired", retired_o, 64'd0);
    check("rst_flags", 64'({halt_o, proto_err_o, wbu_valid_o, rf_we_o, csr_we_o, excp_o}), 64'd0);
    check("rst_epc", 64'(epc_o), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    m_pc  = 32'h8000_0000;
    m_ret = 64'd0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check("init_pc", 64'(pc_o), 64'h8000_0000);
    check("init_retired", retired_o, 64'd0);
    check("init_flags", 64'({halt_o, proto_err_o, wbu_valid_o, rf_we_o, csr_we_o, excp_o}), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    m_pc  = 32'h8000_0000;
    m_ret = 64'd0;

    b = '0; b.gr_we = 1'b1; b.rd = 5'd5; b.result = 32'h1234;
    send(b);
    check("t1_pc", 64'(pc_o), 64'h8000_0004);
    check("t1_retired", retired_o, 64'd1);

    b = '0; b.gr_we = 1'b1; b.rd = 5'd0; b.result = 32'hdead;
    send(b);

    b = '0; b.csr_we = 1'b1; b.csr_addr = 12'h300; b.csr_wdata = 32'h1888;
    send(b);

    b = '0; b.jmp_flag = 1'b1; b.jmp_target = 32'h8000_0100; b.gr_we = 1'b1; b.rd = 5'd1;
    b.result = 32'h8000_0004;
    send(b);
    check("t3_pc", 64'(pc_o), 64'h8000_0100);

    b = '0; b.jmp_flag = 1'b1; b.jmp_target = 32'h8000_0010;
    send(b);

    b = '0; b.excp_flush = 1'b1; b.gr_we = 1'b1; b.rd = 5'd2; b.csr_we = 1'b1;
    send(b);
    check("t4_pc", 64'(pc_o), 64'h8000_0800);
    check("t4_retired", retired_o, 64'd5);

    b = '0; b.xret_flush = 1'b1;
    send(b);
    check("t4_xret_pc", 64'(pc_o), 64'h8000_0010);

    mtvec_i = 32'h8000_0900;
    mepc_i  = 32'h8000_0444;
    b = '0; b.excp_flush = 1'b1; b.xret_flush = 1'b1; b.jmp_flag = 1'b1; b.jmp_target = 32'h8000_0200;
    send(b);
    check("trap_wins_pc", 64'(pc_o), 64'h8000_0900);

    b = '0; b.brk = 1'b1; b.gr_we = 1'b1; b.rd = 5'd4; b.result = 32'h77;
    send(b);
    @(negedge clock);
    lsu_valid_i = 1'b1;
    b = '0; b.gr_we = 1'b1; b.rd = 5'd6;
    lsu_wbu_bus_i = b;
    @(negedge clock);
    lsu_valid_i = 1'b0;
    check("halt_rf_we", 64'(rf_we_o), 64'd0);
    @(negedge clock);
    check("halt_sticky", 64'(halt_o), 64'd1);
    check("halt_no_proto", 64'(proto_err_o), 64'd0);
    check("halt_no_valid", 64'(wbu_valid_o), 64'd0);
    check("halt_retired", retired_o, m_ret);
    do_reset();

    @(negedge clock);
    b = '0; b.gr_we = 1'b1; b.rd = 5'd3; b.result = 32'haaaa;
    lsu_valid_i = 1'b1;
    lsu_wbu_bus_i = b;
    @(negedge clock);
    b = '0; b.gr_we = 1'b1; b.rd = 5'd7; b.result = 32'h5555;
    lsu_wbu_bus_i = b;
    check("t6_rf_we", 64'(rf_we_o), 64'd1);
    check("t6_waddr", 64'(rf_waddr_o), 64'd3);
    check("t6_wdata", 64'(rf_wdata_o), 64'haaaa);
    @(negedge clock);
    lsu_valid_i = 1'b0;
    check("t6_valid", 64'(wbu_valid_o), 64'd1);
    check("t6_pc", 64'(pc_o), 64'h8000_0004);
    check("t6_proto", 64'(proto_err_o), 64'd1);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clock);
      seen = seen | rf_we_o | wbu_valid_o;
    end
    check("t6_no_second", 64'(seen), 64'd0);
    check("t6_retired", retired_o, 64'd1);
    do_reset();

    @(negedge clock);
    b = '0; b.gr_we = 1'b1; b.rd = 5'd9; b.result = 32'h99;
    lsu_valid_i = 1'b1;
    lsu_wbu_bus_i = b;
    @(negedge clock);
    lsu_valid_i = 1'b0;
    check("abort_pre_we", 64'(rf_we_o), 64'd1);
    reset = 1'b1;
    #1;
    check("abort_we", 64'(rf_we_o), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clock);
      seen = seen | wbu_valid_o | rf_we_o;
    end
    check("abort_no_pulse", 64'(seen), 64'd0);
    check("abort_retired", retired_o, 64'd0);
    check("abort_pc", 64'(pc_o), 64'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
